keypad_row_scanner: RTL

// - Upstream stage of decoder_3x8. Generates the 3-bit row select that decoder_3x8 turns into 8 one-hot row drives.
// - Samples the 4 column returns of an 8x4 key matrix and debounces them over whole scan frames.
// - Emits one 5-bit key code per press on a valid/ready handshake.

---
 rtl/keypad_scan_pkg.sv | 37 +++
 rtl/scan_timer.sv | 44 ++++
 rtl/keypad_row_scanner.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_pkg.sv
// Shared types and helpers for the keypad row scanner.
// Latency: n/a (types, constants and combinational helpers only).
// Backpressure: n/a.
package keypad_scan_pkg;

    localparam int ROWS   = 8;
    localparam int COLS   = 4;
    localparam int CODE_W = 5;
    localparam int ROW_W  = $clog2(ROWS);
    localparam int COL_W  = $clog2(COLS);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } scan_state_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        ONE   = 2'd1,
        MULTI = 2'd2
    } frame_class_t;

    // Number of active column returns in one sample.
    function automatic logic [2:0] popcount4(input logic [COLS-1:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    // Index of the lowest set column; only meaningful when exactly one bit is set.
    function automatic logic [COL_W-1:0] col_index(input logic [COLS-1:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else if (v[2]) return 2'd2;
        else           return 2'd3;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Row dwell timer: steps the row select every DWELL cycles and flags sample / frame-end cycles.
// Latency: strobes are combinational from the registered counters (asserted during the sample cycle).
// Backpressure: none; i_scan_en=0 parks the timer at row 0, count 0 on the next edge.
module scan_timer
    import keypad_scan_pkg::*;
#(
    parameter int DWELL = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_scan_en,
    output logic [ROW_W-1:0] o_row_sel,
    output logic             o_sample_stb,
    output logic             o_frame_end
);

    localparam int CNT_W = $clog2(DWELL);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    logic [CNT_W-1:0] r_dwell_cnt;
    logic [ROW_W-1:0] r_row_sel;

    // Dwell counter and row index; a parked scanner restarts cleanly from row 0.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_dwell_cnt <= '0;
            r_row_sel   <= '0;
        end else if (!i_scan_en) begin
            r_dwell_cnt <= '0;
            r_row_sel   <= '0;
        end else if (r_dwell_cnt == LAST_CNT) begin
            r_dwell_cnt <= '0;
            r_row_sel   <= r_row_sel + ROW_W'(1);
        end else begin
            r_dwell_cnt <= r_dwell_cnt + CNT_W'(1);
        end
    end

    assign o_row_sel    = r_row_sel;
    assign o_sample_stb = i_scan_en && (r_dwell_cnt == LAST_CNT);
    assign o_frame_end  = o_sample_stb && (r_row_sel == LAST_ROW);

endmodule

// File: rtl/keypad_row_scanner.sv
// 8x4 keypad scanner: frame-level debounce, one key code per press on a valid/ready output.
// Latency: key_valid rises one cycle after the frame-end edge that accepts the press.
// Backpressure: one-entry output; an event arriving while the entry is held unconsumed is dropped with an overflow pulse.
module keypad_row_scanner
    import keypad_scan_pkg::*;
#(
    parameter int DWELL = 16,
    parameter int DEB   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scan_en,
    output logic [ROW_W-1:0]  row_sel,
    input  logic [COLS-1:0]   col,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              overflow
);

    localparam int DEB_W = $clog2(DEB + 1);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB);

    logic              w_sample_stb;
    logic              w_frame_end;
    logic [ROW_W-1:0]  w_row_sel;

    scan_timer #(.DWELL(DWELL)) u_timer (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_scan_en    (scan_en),
        .o_row_sel    (w_row_sel),
        .o_sample_stb (w_sample_stb),
        .o_frame_end  (w_frame_end)
    );

    assign row_sel = w_row_sel;

    // Frame accumulator: set-bit count saturating at 2 plus the code of the first single hit.
    logic [1:0]        r_acc_cnt;
    logic [CODE_W-1:0] r_acc_code;
    logic [2:0]        w_col_cnt;
    logic [2:0]        w_sum;
    logic [1:0]        w_acc_cnt_nxt;
    logic [CODE_W-1:0] w_acc_code_nxt;
    frame_class_t      w_class;

    assign w_col_cnt      = popcount4(col);
    assign w_sum          = {1'b0, r_acc_cnt} + w_col_cnt;
    assign w_acc_cnt_nxt  = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
    assign w_acc_code_nxt = (r_acc_cnt == 2'd0 && w_col_cnt == 3'd1) ?
                            {w_row_sel, col_index(col)} : r_acc_code;

    // Classify the frame including the row-7 sample taken this cycle.
    always_comb begin
        w_class = MULTI;
        case (w_acc_cnt_nxt)
            2'd0:    w_class = NONE;
            2'd1:    w_class = ONE;
            default: w_class = MULTI;
        endcase
    end

    // Accumulate samples across a frame; cleared at frame end or when scanning parks.
    always_ff @(posedge clk) begin
        if (!rst_n || !scan_en || w_frame_end) begin
            r_acc_cnt  <= '0;
            r_acc_code <= '0;
        end else if (w_sample_stb) begin
            r_acc_cnt  <= w_acc_cnt_nxt;
            r_acc_code <= w_acc_code_nxt;
        end
    end

    // Debounce FSM, stepped once per completed frame; r_emit is a one-cycle request to the output stage.
    scan_state_t       r_state;
    logic [CODE_W-1:0] r_cand;
    logic [DEB_W-1:0]  r_deb_cnt;
    logic              r_emit;
    logic [CODE_W-1:0] r_emit_code;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= SCAN;
            r_cand      <= '0;
            r_deb_cnt   <= '0;
            r_emit      <= 1'b0;
            r_emit_code <= '0;
        end else begin
            r_emit <= 1'b0;
            if (w_frame_end) begin
                case (r_state)
                    SCAN: begin
                        if (w_class == ONE) begin
                            r_cand    <= w_acc_code_nxt;
                            r_deb_cnt <= DEB_W'(1);
                            if (DEB == 1) begin
                                r_emit      <= 1'b1;
                                r_emit_code <= w_acc_code_nxt;
                                r_state     <= HELD;
                            end else begin
                                r_state <= DEBOUNCE;
                            end
                        end
                    end
                    DEBOUNCE: begin
                        if (w_class == ONE && w_acc_code_nxt == r_cand) begin
                            if (r_deb_cnt == DEB_MAX - DEB_W'(1)) begin
                                r_deb_cnt   <= DEB_MAX;
                                r_emit      <= 1'b1;
                                r_emit_code <= r_cand;
                                r_state     <= HELD;
                            end else if (r_deb_cnt != DEB_MAX) begin
                                r_deb_cnt <= r_deb_cnt + DEB_W'(1);
                            end
                        end else if (w_class == ONE) begin
                            r_cand    <= w_acc_code_nxt;
                            r_deb_cnt <= DEB_W'(1);
                        end else begin
                            r_deb_cnt <= '0;
                            r_state   <= SCAN;
                        end
                    end
                    HELD: begin
                        if (w_class == NONE) begin
                            r_deb_cnt <= '0;
                            r_state   <= SCAN;
                        end
                    end
                    default: begin
                        r_deb_cnt <= '0;
                        r_state   <= SCAN;
                    end
                endcase
            end
        end
    end

    // One-entry output register: accept-and-reload in one cycle, else drop with an overflow pulse.
    logic              r_key_valid;
    logic [CODE_W-1:0] r_key_code;
    logic              r_overflow;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_key_valid <= 1'b0;
            r_key_code  <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_overflow <= 1'b0;
            if (r_emit) begin
                if (!r_key_valid || key_ready) begin
                    r_key_valid <= 1'b1;
                    r_key_code  <= r_emit_code;
                end else begin
                    r_overflow <= 1'b1;
                end
            end else if (r_key_valid && key_ready) begin
                r_key_valid <= 1'b0;
            end
        end
    end

    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;
    assign overflow  = r_overflow;

endmodule
